// File: rtl/riscv_regfile_pkg.sv
// Shared constants for the parametrised RV32I integer register file.
// Contents: read-mode selectors, default geometry, zero-register index.
package riscv_regfile_pkg;

  // READ_SYNC parameter values
  localparam int unsigned RF_READ_COMB = 0;
  localparam int unsigned RF_READ_SYNC = 1;

  // Default architectural geometry (RV32I)
  localparam int unsigned RF_XLEN_DEFAULT  = 32;
  localparam int unsigned RF_NREGS_DEFAULT = 32;

  // x0 is hardwired to zero
  localparam int unsigned RF_ZERO_REG = 0;

endpackage

// File: rtl/riscv_regfile_mp_read_port.sv
// One register-file read port: address decode, storage mux, write-through
// bypass compare and an optional output register.
// Ports:
//   clk, rst        clock and async active-high reset (output register only)
//   rd_en           capture enable for the output register
//   rd_addr         read address
//   wr_en/addr/data all write ports (wr_en already gated by reset in the top)
//   rf_flat         flattened storage contents, register r at [r*XLEN +: XLEN]
//   rd_data         read result (combinational or registered per READ_SYNC)
module regfile_read_port
  import riscv_regfile_pkg::*;
#(
  parameter  int unsigned XLEN      = RF_XLEN_DEFAULT,
  parameter  int unsigned NREGS     = RF_NREGS_DEFAULT,
  parameter  int unsigned NWR       = 1,
  parameter  int unsigned READ_SYNC = RF_READ_COMB,
  parameter  int unsigned BYPASS    = 1,
  localparam int unsigned AW        = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*XLEN-1:0]   wr_data,
  input  logic [NREGS*XLEN-1:0] rf_flat,
  output logic [XLEN-1:0]       rd_data
);

  logic [XLEN-1:0] stored_c;
  logic [XLEN-1:0] read_c;
  logic [XLEN-1:0] rd_q;

  // Storage mux: select the addressed register
  always_comb begin : storage_mux
    stored_c = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (rd_addr == AW'(r)) stored_c = rf_flat[r*XLEN +: XLEN];
    end
  end

  // Write-through bypass; later ports override earlier ones, x0 always 0
  always_comb begin : bypass_select
    read_c = stored_c;
    if (BYPASS != 0) begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr)) read_c = wr_data[j*XLEN +: XLEN];
      end
    end
    if (rd_addr == AW'(RF_ZERO_REG)) read_c = '0;
  end

  // Output register; holds its value while rd_en is low
  always_ff @(posedge clk or posedge rst) begin : out_reg
    if (rst)        rd_q <= '0;
    else if (rd_en) rd_q <= read_c;
  end

  assign rd_data = (READ_SYNC == RF_READ_SYNC) ? rd_q : read_c;

endmodule

// File: rtl/riscv_regfile_mp.sv
// Parametrised multi-port integer register file for the RV32I core.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset; clears all registers at once
//   rd_en    per-port read enable (registered-read mode only)
//   rd_addr  read addresses, port i at [i*AW +: AW]
//   rd_data  read data, port i at [i*XLEN +: XLEN]
//   wr_en    per-port write enable
//   wr_addr  write addresses, port j at [j*AW +: AW]
//   wr_data  write data, port j at [j*XLEN +: XLEN]
module riscv_regfile_mp
  import riscv_regfile_pkg::*;
#(
  parameter  int unsigned XLEN      = RF_XLEN_DEFAULT,
  parameter  int unsigned NREGS     = RF_NREGS_DEFAULT,
  parameter  int unsigned NRD       = 2,
  parameter  int unsigned NWR       = 1,
  parameter  int unsigned READ_SYNC = RF_READ_COMB,
  parameter  int unsigned BYPASS    = 1,
  localparam int unsigned AW        = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data
);

  logic [XLEN-1:0]       regs_q [NREGS];
  logic [NREGS*XLEN-1:0] rf_flat;
  logic [NWR-1:0]        wr_en_eff;

  // Writes are dropped while reset is held, including on the bypass path
  assign wr_en_eff = wr_en & {NWR{~rst}};

  // Storage with write priority: later ports are applied last and win; x0 never written
  always_ff @(posedge clk or posedge rst) begin : write_commit
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(RF_ZERO_REG)))
          regs_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  // Flatten storage for the read ports
  always_comb begin : flatten
    rf_flat = '0;
    for (int unsigned r = 0; r < NREGS; r++) rf_flat[r*XLEN +: XLEN] = regs_q[r];
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_read_port #(
      .XLEN      (XLEN),
      .NREGS     (NREGS),
      .NWR       (NWR),
      .READ_SYNC (READ_SYNC),
      .BYPASS    (BYPASS)
    ) u_rd (
      .clk     (clk),
      .rst     (rst),
      .rd_en   (rd_en[i]),
      .rd_addr (rd_addr[i*AW +: AW]),
      .wr_en   (wr_en_eff),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rf_flat (rf_flat),
      .rd_data (rd_data[i*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Bench for riscv_regfile_mp: four configurations driven by shared stimulus,
// checked every cycle against an array-based model of the register file.
//   u0: 32x32, 4R/2W, combinational, bypass
//   u1: 32x32, 4R/2W, registered,    bypass
//   u2: 32x32, 4R/2W, combinational, no bypass
//   u3: 16x64, 4R/2W, registered,    bypass
module tb_riscv_regfile_mp;

  logic        clk;
  logic        rst;
  logic [3:0]  rd_en;
  logic [1:0]  wr_en;
  logic [4:0]  ra [4];
  logic [4:0]  wa [2];
  logic [63:0] wd [2];

  logic [19:0]  ra_bus5;
  logic [15:0]  ra_bus4;
  logic [9:0]   wa_bus5;
  logic [7:0]   wa_bus4;
  logic [63:0]  wd_bus32;
  logic [127:0] wd_bus64;
  logic [127:0] q0, q1, q2;
  logic [255:0] q3;

  // Model state
  logic [31:0] m32 [32];
  logic [63:0] m16 [16];
  logic [31:0] s1  [4];
  logic [63:0] s3  [4];

  int errors = 0;
  int checks = 0;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ra_bus5[i*5 +: 5] = ra[i];
      ra_bus4[i*4 +: 4] = ra[i][3:0];
    end
    for (int j = 0; j < 2; j++) begin
      wa_bus5[j*5 +: 5]    = wa[j];
      wa_bus4[j*4 +: 4]    = wa[j][3:0];
      wd_bus32[j*32 +: 32] = wd[j][31:0];
      wd_bus64[j*64 +: 64] = wd[j];
    end
  end

  riscv_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(4), .NWR(2), .READ_SYNC(0), .BYPASS(1)) u0 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(ra_bus5), .rd_data(q0),
    .wr_en(wr_en), .wr_addr(wa_bus5), .wr_data(wd_bus32));
  riscv_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(4), .NWR(2), .READ_SYNC(1), .BYPASS(1)) u1 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(ra_bus5), .rd_data(q1),
    .wr_en(wr_en), .wr_addr(wa_bus5), .wr_data(wd_bus32));
  riscv_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(4), .NWR(2), .READ_SYNC(0), .BYPASS(0)) u2 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(ra_bus5), .rd_data(q2),
    .wr_en(wr_en), .wr_addr(wa_bus5), .wr_data(wd_bus32));
  riscv_regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4), .NWR(2), .READ_SYNC(1), .BYPASS(1)) u3 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(ra_bus4), .rd_data(q3),
    .wr_en(wr_en), .wr_addr(wa_bus4), .wr_data(wd_bus64));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- model ----------------
  // What a read of address a sees this cycle: x0 is 0, otherwise the stored
  // value, replaced (with bypass) by the highest-numbered matching write.
  function automatic logic [31:0] exp32(input logic [4:0] a, input bit byp);
    logic [31:0] v;
    if (a == 5'd0) return 32'd0;
    v = m32[a];
    if (byp && !rst)
      for (int j = 0; j < 2; j++) if (wr_en[j] && wa[j] == a) v = wd[j][31:0];
    return v;
  endfunction

  function automatic logic [63:0] exp64(input logic [3:0] a);
    logic [63:0] v;
    if (a == 4'd0) return 64'd0;
    v = m16[a];
    if (!rst)
      for (int j = 0; j < 2; j++) if (wr_en[j] && wa[j][3:0] == a) v = wd[j];
    return v;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 32; r++) m32[r] = '0;
    for (int r = 0; r < 16; r++) m16[r] = '0;
    for (int i = 0; i < 4; i++) begin s1[i] = '0; s3[i] = '0; end
  endtask

  // Advance the model across one rising edge
  task automatic model_edge();
    if (rst) begin
      clear_model();
    end else begin
      for (int i = 0; i < 4; i++) if (rd_en[i]) begin
        s1[i] = exp32(ra[i], 1'b1);
        s3[i] = exp64(ra[i][3:0]);
      end
      for (int j = 0; j < 2; j++) if (wr_en[j]) begin
        if (wa[j] != 5'd0)      m32[wa[j]]      = wd[j][31:0];
        if (wa[j][3:0] != 4'd0) m16[wa[j][3:0]] = wd[j];
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input int port, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s port%0d: got %h, expected %h at %0t", name, port, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      check("u0_comb_byp",  i, 64'(q0[i*32 +: 32]), 64'(exp32(ra[i], 1'b1)));
      check("u1_sync_byp",  i, 64'(q1[i*32 +: 32]), 64'(s1[i]));
      check("u2_comb_nobyp", i, 64'(q2[i*32 +: 32]), 64'(exp32(ra[i], 1'b0)));
      check("u3_sync_x64",  i, q3[i*64 +: 64], s3[i]);
    end
  endtask

  task automatic cmp();
    @(negedge clk);
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    wr_en = '0;
    rd_en = '0;
    for (int i = 0; i < 4; i++) ra[i] = '0;
    for (int j = 0; j < 2; j++) begin wa[j] = '0; wd[j] = '0; end
  endtask

  task automatic set_reads(input logic [4:0] a, input logic [3:0] en);
    for (int i = 0; i < 4; i++) ra[i] = a;
    rd_en = en;
  endtask

  task automatic set_write(input int port, input logic [4:0] a, input logic [63:0] d);
    wr_en[port] = 1'b1;
    wa[port]    = a;
    wd[port]    = d;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 2) == 0) return 5'($urandom_range(0, 3));
    return 5'($urandom);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    set_idle();
    clear_model();
    #1;
    compare_all();
    check("reset_u1_port0", 0, 64'(q1[31:0]), 64'd0);
    check("reset_u3_port3", 3, q3[255:192], 64'd0);
    tick();
    cmp();
    tick();
    rst = 1'b0;

    // Same-cycle write/read of x7: bypass returns new data, no-bypass old (0)
    set_idle();
    set_write(0, 5'd7, 64'h1234);
    set_reads(5'd7, 4'b0001);
    cmp();
    check("byp_x7_same_cycle", 0, 64'(q0[31:0]), 64'h1234);
    check("nobyp_x7_same_cycle", 0, 64'(q2[31:0]), 64'h0);
    tick();
    wr_en = '0;
    cmp();
    check("sync_x7_captured", 0, 64'(q1[31:0]), 64'h1234);
    check("nobyp_x7_next", 0, 64'(q2[31:0]), 64'h1234);
    tick();

    // Write to x0 is discarded
    set_idle();
    set_write(0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    set_reads(5'd0, 4'b1111);
    cmp();
    check("x0_write_cycle", 0, 64'(q0[31:0]), 64'h0);
    tick();
    wr_en = '0;
    cmp();
    check("x0_next_cycle", 0, 64'(q0[31:0]), 64'h0);
    check("x0_sync", 0, 64'(q1[31:0]), 64'h0);
    tick();

    // Two ports writing x3 in one cycle: port 1 wins
    set_idle();
    set_write(0, 5'd3, 64'hAAAA);
    set_write(1, 5'd3, 64'h5555);
    set_reads(5'd3, 4'b0001);
    cmp();
    check("prio_bypass_x3", 0, 64'(q0[31:0]), 64'h5555);
    tick();
    wr_en = '0;
    cmp();
    check("prio_stored_x3", 0, 64'(q2[31:0]), 64'h5555);
    check("prio_sync_x3", 0, 64'(q1[31:0]), 64'h5555);
    tick();

    // Registered read of x9 then hold with rd_en low
    set_idle();
    set_write(0, 5'd9, 64'h42);
    cmp();
    tick();
    set_idle();
    set_reads(5'd9, 4'b0001);
    cmp();
    tick();
    set_reads(5'd0, 4'b0000);
    cmp();
    check("sync_x9_latency1", 0, 64'(q1[31:0]), 64'h42);
    tick();
    cmp();
    check("sync_x9_hold", 0, 64'(q1[31:0]), 64'h42);
    tick();

    // All ports read the top register
    set_idle();
    set_write(0, 5'd31, 64'h8000_0001);
    cmp();
    tick();
    set_idle();
    set_reads(5'd31, 4'b1111);
    cmp();
    for (int i = 0; i < 4; i++) check("allports_x31_comb", i, 64'(q0[i*32 +: 32]), 64'h8000_0001);
    tick();
    cmp();
    for (int i = 0; i < 4; i++) begin
      check("allports_x31_sync", i, 64'(q1[i*32 +: 32]), 64'h8000_0001);
      check("allports_x15_x64", i, q3[i*64 +: 64], 64'h8000_0001);
    end
    tick();

    // Asynchronous reset mid-cycle after writing x5
    set_idle();
    set_write(0, 5'd5, 64'hDEAD_BEEF);
    set_reads(5'd5, 4'b1111);
    cmp();
    tick();
    wr_en = '0;
    rd_en = '0;
    cmp();
    check("pre_reset_x5_comb", 0, 64'(q0[31:0]), 64'hDEAD_BEEF);
    check("pre_reset_x5_sync", 0, 64'(q1[31:0]), 64'hDEAD_BEEF);
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    compare_all();
    check("async_reset_x5_comb", 0, 64'(q0[31:0]), 64'h0);
    check("async_reset_x5_sync", 0, 64'(q1[31:0]), 64'h0);
    check("async_reset_x5_x64", 0, q3[63:0], 64'h0);
    set_write(0, 5'd5, 64'h1111);
    tick();
    cmp();
    tick();
    rst = 1'b0;
    cmp();
    tick();
    set_idle();
    set_reads(5'd5, 4'b1111);
    cmp();
    check("post_reset_first_write", 0, 64'(q2[31:0]), 64'h1111);
    tick();

    // Randomized traffic with address collisions
    repeat (600) begin
      for (int i = 0; i < 4; i++) ra[i] = rand_addr();
      for (int j = 0; j < 2; j++) begin
        wa[j] = rand_addr();
        wd[j] = {$urandom, $urandom};
      end
      wr_en = 2'($urandom);
      rd_en = 4'($urandom);
      cmp();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
